// File: rtl/div16by8_seq_if.sv
// div16by8_seq_if: operand/result bundle for the sequential divider.
//   master : producer/consumer side (drives start, N, D, ack)
//   slave  : divider side (drives ready, valid, Q, R, dz, ovf)
//   start/ready : operand handshake, N (2*WIDTH) and D (WIDTH) sampled on start & ready
//   valid/ack   : result handshake, Q/R/dz/ovf held while valid until ack
interface div16by8_seq_if #(parameter int WIDTH = 8);
  logic               start;
  logic [2*WIDTH-1:0] N;
  logic [WIDTH-1:0]   D;
  logic               ready;
  logic               valid;
  logic               ack;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   R;
  logic               dz;
  logic               ovf;

  modport master (output start, N, D, ack, input ready, valid, Q, R, dz, ovf);
  modport slave  (input start, N, D, ack, output ready, valid, Q, R, dz, ovf);
endinterface

// File: rtl/div16by8_seq.sv
// div16by8_seq: sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : div16by8_seq_if.slave (start/ready operand handshake, valid/ack result
//          handshake, Q quotient, R remainder, dz divide-by-zero, ovf overflow)
// Optional macro DIV_BACKTOBACK_EN: in DONE, ready follows ack so a new operand
// pair can be accepted on the same edge that retires the current result.
//
// state | meaning
// IDLE  | ready for operands, last result still visible on Q/R
// RUN   | restoring steps in progress, one quotient bit per edge
// DONE  | result valid, waiting for ack
module div16by8_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  div16by8_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic              ready_q;
  logic              valid_q;
  logic              dz_q;
  logic              ovf_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  d_q;
  logic [CW-1:0]     cnt;

  logic              ready_c;
  logic              accept;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    diff;
  logic              ge;
  logic [WIDTH-1:0]  rem_nxt;
  logic [WIDTH-1:0]  sh_nxt;

  // One restoring step. The trial is WIDTH+1 bits because the shifted-in
  // remainder can exceed the divisor range before subtraction.
  always_comb begin
    trial   = {rem, shreg[WIDTH-1]};
    diff    = trial - {1'b0, d_q};
    ge      = (trial >= {1'b0, d_q});
    rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    // dividend bits leave at the MSB while quotient bits enter at the LSB
    sh_nxt  = {shreg[WIDTH-2:0], ge};
  end

`ifdef DIV_BACKTOBACK_EN
  assign ready_c = ready_q | ((state == DONE) & bus.ack);
`else
  assign ready_c = ready_q;
`endif

  assign accept    = bus.start & ready_c;
  assign bus.ready = ready_c;
  assign bus.valid = valid_q;
  assign bus.Q     = q_q;
  assign bus.R     = r_q;
  assign bus.dz    = dz_q;
  assign bus.ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      rem     <= '0;
      shreg   <= '0;
      d_q     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        RUN: begin
          rem   <= rem_nxt;
          shreg <= sh_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= DONE;
            valid_q <= 1'b1;
            q_q     <= sh_nxt;
            r_q     <= rem_nxt;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.ack) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase

      // Operand capture comes last so a back-to-back accept in DONE overrides
      // the ack return to IDLE above.
      if (accept) begin
        d_q     <= bus.D;
        ready_q <= 1'b0;
        if (bus.D == '0) begin
          state   <= DONE;
          valid_q <= 1'b1;
          dz_q    <= 1'b1;
          ovf_q   <= 1'b0;
          q_q     <= '1;
          r_q     <= bus.N[WIDTH-1:0];
        end else if (bus.N[2*WIDTH-1:WIDTH] >= bus.D) begin
          state   <= DONE;
          valid_q <= 1'b1;
          dz_q    <= 1'b0;
          ovf_q   <= 1'b1;
          q_q     <= '1;
          r_q     <= bus.N[WIDTH-1:0];
        end else begin
          state   <= RUN;
          valid_q <= 1'b0;
          rem     <= bus.N[2*WIDTH-1:WIDTH];
          shreg   <= bus.N[WIDTH-1:0];
          cnt     <= '0;
        end
      end
    end
  end
endmodule

// File: doc/div16by8_seq.md
Name: div16by8_seq

Overview:
Sequential restoring divider. It is the inverse of the team's 8x8 gate-level array multiplier: it takes a 16-bit dividend and an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. The block sits beside the multiplier in the arithmetic datapath and produces one quotient bit per clock. Operands come in through a start/ready handshake; results go out through a valid/ack handshake.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits. Only 8 is verified.

Ports:
clk     input   1        single clock, rising edge
rst     input   1        synchronous reset, active-high
start   input   1        request; operands sampled on the edge where start & ready
N       input   16       dividend (2*WIDTH)
D       input   8        divisor
ready   output  1        block can accept start
valid   output  1        Q/R/dz/ovf are valid; held until ack
ack     input   1        consumer accepts result; effective only when valid
Q       output  8        quotient
R       output  8        remainder
dz      output  1        divide-by-zero flag, qualified by valid
ovf     output  1        quotient overflow flag (N[15:8] >= D, D != 0), qualified by valid

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (clk, rst).
- Reset (edge with rst=1, overrides everything): state=IDLE, ready=1, valid=0, Q=0, R=0, dz=0, ovf=0, counter=0.
- Reset mid-RUN or in DONE abandons the operation. No partial result is ever flagged valid.
- FSM states IDLE, RUN, DONE:
  - IDLE: ready=1. On start, capture N and D, then:
    - D==0: go to DONE with dz=1, ovf=0, Q=8'hFF, R=N[7:0].
    - else N[15:8]>=D: go to DONE with ovf=1, dz=0, Q=8'hFF, R=N[7:0].
    - else: go to RUN with partial remainder = N[15:8], shift register = N[7:0], counter=0.
  - RUN: ready=0. Each edge performs one restoring step:
    - trial = {rem, msb of shift} (9 bits); if trial >= D then rem = trial - D and bit = 1, else rem = trial[7:0] and bit = 0.
    - Shift bit into the quotient LSB-side; counter++.
    - After the WIDTH-th step go to DONE with Q = quotient, R = rem, dz=0, ovf=0.
  - DONE: valid=1. Q/R/dz/ovf are stable until the ack edge. On ack go to IDLE with valid=0; Q/R keep their last values.
- Latency:
  - Normal path: valid is high WIDTH+1 cycles after the accept edge (1 capture edge + 8 RUN edges).
  - dz/ovf fast path: valid is high in the cycle after the accept edge.
- start while ready=0 is ignored: no capture, no state change.
- ack while valid=0 is ignored.
- Simultaneous start and ack in DONE: ack is honoured; start is dropped unless the optional feature is compiled in.
- Arithmetic: unsigned only. The invariant Q*D + R == N holds whenever dz=0 and ovf=0, and then R < D.

Optional Feature:
Macro DIV_BACKTOBACK_EN.
- Defined:
  - In DONE, ready = ack (combinational).
  - start & ack on the same edge drops valid and captures the new operands as in IDLE (into RUN, or DONE for the fast path). No idle bubble.
  - Max throughput is one result per WIDTH+1 cycles.
- Undefined:
  - ready=0 in DONE.
  - A mandatory IDLE cycle separates results.
  - Max throughput is one result per WIDTH+2 cycles.

Test Plan:
- Reset, then N=16'd1000, D=8'd7, start for 1 cycle -> valid after 9 cycles; Q=8'd142, R=8'd6, dz=0, ovf=0; held until ack; ready=1 the cycle after the ack edge.
- N=16'hFEFF, D=8'hFF -> Q=8'hFF, R=8'hFE, ovf=0 (max legal quotient, 9-bit trial path).
- N=16'd1234, D=0 -> valid 1 cycle after accept; dz=1, ovf=0, Q=8'hFF, R=8'hD2. Then N=16'h0700, D=8'd7 -> ovf=1, dz=0, Q=8'hFF, R=8'h00.
- Pulse start with new operands at RUN cycle 4 -> ignored; result still 1000/7 = 142 r 6. Assert ack with valid=0 -> no effect.
- Assert rst at RUN cycle 5 -> next cycle ready=1, valid=0, Q=0, R=0. A new op N=16'd255, D=8'd16 then gives Q=8'd15, R=8'd15.
- With DIV_BACKTOBACK_EN: in DONE, drive ack+start with N=16'd500, D=8'd9 -> next result Q=8'd55, R=8'd5, valid 9 cycles later. Without the macro the same stimulus drops the start and ready rises one cycle after ack.
